// File: rtl/countdown_sequencer_if.sv
// Race-start controller signal bundle: start/abort controls, countdown counter link, display.
// Latency: none, wiring only.
// Backpressure: none; all signals are levels or single-cycle pulses.
interface countdown_sequencer_if;
    logic       start;
    logic       abort;
    logic       countFinish;
    logic [1:0] countDetail;
    logic       countEnable;
    logic       go_pulse;
    logic       race_go;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    // Sequencer side
    modport master (
        input  start, abort, countFinish, countDetail,
        output countEnable, go_pulse, race_go, busy, an, seg
    );

    // Buttons, countdown counter and display side
    modport slave (
        output start, abort, countFinish, countDetail,
        input  countEnable, go_pulse, race_go, busy, an, seg
    );
endinterface

// File: rtl/countdown_sequencer.sv
// Race-start sequencer: IDLE -> 3/2/1/GO countdown -> RUN, plus 4-digit 7-segment scan.
// Latency: every output is registered; a decision at an edge is visible right after that edge.
// Backpressure: none; abort overrides everything and returns to IDLE on the next edge.
module countdown_sequencer #(
    parameter int SCAN_BITS      = 18,
    parameter int GO_HOLD_CYCLES = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    countdown_sequencer_if.master bus
);
    localparam int HOLD_W = (GO_HOLD_CYCLES > 1) ? $clog2(GO_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(GO_HOLD_CYCLES - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_G     = 7'b1000010;
    localparam logic [6:0] SEG_O     = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_GO    = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                start_q;
    logic                fin_q;
    logic                start_rise;
    logic                fin_rise;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [SCAN_BITS-1:0] scan;
    logic [SCAN_BITS-1:0] scan_nxt;
    logic [1:0]          sel;
    logic [3:0]          an_nxt;
    logic [6:0]          seg_nxt;
    logic [6:0]          seg_go;

    assign start_rise = bus.start & ~start_q;
    assign fin_rise   = bus.countFinish & ~fin_q;

    // Next state and GO hold counter; abort has priority over every transition.
    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_rise) state_nxt = S_COUNT;
                S_COUNT: if (fin_rise) state_nxt = S_GO;
                S_GO: begin
                    if (hold == HOLD_LAST) state_nxt = S_RUN;
                    else                   hold_nxt  = hold + HOLD_W'(1);
                end
                S_RUN:   state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Display pattern for the digit selected by the upcoming scan value, so an and seg
    // always change together.
    always_comb begin
        scan_nxt = scan + SCAN_BITS'(1);
        sel      = scan_nxt[SCAN_BITS-1 -: 2];
        an_nxt   = ~(4'b0001 << sel);
        seg_go   = (sel == 2'd1) ? SEG_G : ((sel == 2'd0) ? SEG_O : SEG_BLANK);
        seg_nxt  = SEG_BLANK;
        case (state_nxt)
            S_IDLE: seg_nxt = SEG_DASH;
            S_COUNT: begin
                case (bus.countDetail)
                    2'd0:    seg_nxt = (sel == 2'd0) ? SEG_3 : SEG_BLANK;
                    2'd1:    seg_nxt = (sel == 2'd0) ? SEG_2 : SEG_BLANK;
                    2'd2:    seg_nxt = (sel == 2'd0) ? SEG_1 : SEG_BLANK;
                    default: seg_nxt = seg_go;
                endcase
            end
            S_GO:    seg_nxt = seg_go;
            default: seg_nxt = SEG_BLANK;
        endcase
    end

    // State, edge detectors, hold and scan counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            fin_q   <= 1'b0;
            hold    <= '0;
            scan    <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= bus.start;
            fin_q   <= bus.countFinish;
            hold    <= hold_nxt;
            scan    <= scan_nxt;
        end
    end

    // Registered outputs derived from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.countEnable <= 1'b0;
            bus.go_pulse    <= 1'b0;
            bus.race_go     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.an          <= 4'b1111;
            bus.seg         <= SEG_BLANK;
        end else begin
            bus.countEnable <= (state_nxt == S_COUNT);
            bus.go_pulse    <= (state == S_COUNT) && (state_nxt == S_GO);
            bus.race_go     <= (state_nxt == S_RUN);
            bus.busy        <= (state_nxt != S_IDLE);
            bus.an          <= an_nxt;
            bus.seg         <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_countdown_sequencer.sv
// Testbench for countdown_sequencer: behavioural countdown-counter environment plus a
// cycle reference model of the race-start rules, directed scenarios then random stimulus.
module tb_countdown_sequencer;
    localparam int SCAN_BITS = 4;
    localparam int GO_HOLD   = 20;
    localparam int SEC       = 20;   // counter "second" length in clk cycles
    localparam int SCAN_LEN  = 16;   // 2**SCAN_BITS
    localparam int M_IDLE = 0, M_COUNT = 1, M_GO = 2, M_RUN = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    countdown_sequencer_if bus();

    countdown_sequencer #(
        .SCAN_BITS      (SCAN_BITS),
        .GO_HOLD_CYCLES (GO_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int   m_mode;
    int   m_go_age;
    int   m_edges;
    logic m_start_prev;
    logic m_fin_prev;
    int   cyc;
    int   pulses_seen;

    // External countdown counter model
    int   c_ticks;
    int   c_detail;
    logic c_fin;
    logic force_fin;

    function automatic logic [6:0] exp_seg(input int mode, input int sel, input logic [1:0] det);
        logic [6:0] go_word;
        go_word = (sel == 1) ? 7'b1000010 : ((sel == 0) ? 7'b1000000 : 7'b1111111);
        if (mode == M_IDLE) return 7'b0111111;
        if (mode == M_GO)   return go_word;
        if (mode == M_RUN)  return 7'b1111111;
        if (det == 2'd3)    return go_word;
        if (sel != 0)       return 7'b1111111;
        if (det == 2'd0)    return 7'b0110000;
        if (det == 2'd1)    return 7'b0100100;
        return 7'b1111001;
    endfunction

    task automatic drive_counter();
        if (!bus.countEnable) begin
            c_ticks  = 0;
            c_detail = 0;
            c_fin    = 1'b0;
        end else begin
            c_ticks++;
            if (c_ticks == SEC) begin
                c_ticks = 0;
                if (c_detail < 3) c_detail++;
                else              c_fin = 1'b1;
            end
        end
        bus.countDetail = 2'(c_detail);
        bus.countFinish = c_fin | force_fin;
    endtask

    task automatic tick();
        logic       p_start, p_abort, p_fin, rise, frise, exp_pulse;
        logic [1:0] p_det;
        logic [3:0] exp_an;
        int         sel;
        p_start = bus.start;
        p_abort = bus.abort;
        p_fin   = bus.countFinish;
        p_det   = bus.countDetail;
        @(posedge clk);
        #1;
        cyc++;
        rise  = p_start & ~m_start_prev;
        frise = p_fin & ~m_fin_prev;
        m_start_prev = p_start;
        m_fin_prev   = p_fin;
        exp_pulse = 1'b0;
        if (p_abort) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (rise) m_mode = M_COUNT;
        end else if (m_mode == M_COUNT) begin
            if (frise) begin
                m_mode    = M_GO;
                m_go_age  = 0;
                exp_pulse = 1'b1;
            end
        end else if (m_mode == M_GO) begin
            m_go_age++;
            if (m_go_age == GO_HOLD) m_mode = M_RUN;
        end
        m_edges++;
        sel    = (m_edges % SCAN_LEN) / (SCAN_LEN / 4);
        exp_an = ~(4'b0001 << sel);
        check("an", bus.an, exp_an);
        check("seg", bus.seg, exp_seg(m_mode, sel, p_det));
        check("count_enable", bus.countEnable, m_mode == M_COUNT);
        check("busy", bus.busy, m_mode != M_IDLE);
        check("race_go", bus.race_go, m_mode == M_RUN);
        check("go_pulse", bus.go_pulse, exp_pulse);
        if (bus.go_pulse) pulses_seen++;
        drive_counter();
    endtask

    // Asserts rst between clock edges, checks the immediate output values, releases it.
    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_an", bus.an, 4'b1111);
        check("rst_seg", bus.seg, 7'b1111111);
        check("rst_count_enable", bus.countEnable, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_race_go", bus.race_go, 1'b0);
        check("rst_go_pulse", bus.go_pulse, 1'b0);
        m_mode = M_IDLE; m_go_age = 0; m_edges = 0;
        m_start_prev = 1'b0; m_fin_prev = 1'b0;
        c_ticks = 0; c_detail = 0; c_fin = 1'b0; force_fin = 1'b0;
        bus.countDetail = 2'd0;
        bus.countFinish = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int go_at;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.countDetail = 2'd0;
        bus.countFinish = 1'b0;
        cyc = 0;
        pulses_seen = 0;
        async_reset();

        // IDLE dashes across a full scan period
        repeat (20) tick();

        // Normal run
        bus.start = 1'b1;
        tick();
        check("ce_after_start", bus.countEnable, 1'b1);
        pulses_seen = 0;
        go_at = -1000;
        n = 0;
        while (!bus.race_go && n < 400) begin
            tick();
            n++;
            if (bus.go_pulse) go_at = cyc;
        end
        check("run_reached", bus.race_go, 1'b1);
        check("go_to_run_cycles", cyc - go_at, GO_HOLD);
        check("run_pulse_count", pulses_seen, 1);

        // Abort in RUN drops race_go next cycle
        bus.abort = 1'b1;
        tick();
        check("abort_run_drop", bus.race_go, 1'b0);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();

        // Abort during COUNT at countDetail=2
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pulses_seen = 0;
        n = 0;
        while (bus.countDetail != 2'd2 && n < 200) begin tick(); n++; end
        check("reach_detail2", bus.countDetail, 2'd2);
        bus.abort = 1'b1;
        tick();
        check("abort_count_busy", bus.busy, 1'b0);
        check("abort_count_ce", bus.countEnable, 1'b0);
        bus.abort = 1'b0;
        repeat (100) tick();
        check("abort_no_pulse", pulses_seen, 0);
        bus.start = 1'b1;
        tick();
        check("restart_ce", bus.countEnable, 1'b1);
        n = 0;
        while (bus.an != 4'b1110 && n < 20) begin tick(); n++; end
        check("restart_digit3", bus.seg, 7'b0110000);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        tick();

        // start and abort on the same edge in IDLE; held start must not retrigger
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        check("start_abort_same_edge", bus.busy, 1'b0);
        bus.abort = 1'b0;
        repeat (5) tick();
        check("held_start_no_retrigger", bus.busy, 1'b0);
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        check("fresh_rise_triggers", bus.busy, 1'b1);

        // Repeated start pulses through COUNT/GO/RUN
        pulses_seen = 0;
        n = 0;
        while (!bus.race_go && n < 400) begin
            bus.start = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("jitter_run_reached", bus.race_go, 1'b1);
        repeat (30) begin
            bus.start = 1'($urandom_range(0, 1));
            tick();
        end
        check("jitter_run_holds", bus.race_go, 1'b1);
        check("jitter_pulse_count", pulses_seen, 1);
        bus.abort = 1'b1;
        tick();
        check("jitter_abort_drop", bus.race_go, 1'b0);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        tick();

        // countFinish already high at COUNT entry
        force_fin = 1'b1;
        bus.countFinish = 1'b1;
        repeat (3) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pulses_seen = 0;
        repeat (30) tick();
        check("fin_high_no_go", pulses_seen, 0);
        check("fin_high_still_count", bus.countEnable, 1'b1);
        force_fin = 1'b0;
        n = 0;
        while (pulses_seen == 0 && n < 200) begin tick(); n++; end
        check("fin_rise_go", pulses_seen, 1);
        n = 0;
        while (!bus.race_go && n < 100) begin tick(); n++; end
        check("fin_run_reached", bus.race_go, 1'b1);

        // Asynchronous reset in the middle of a countdown
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b1;
        repeat (10) tick();
        async_reset();
        bus.start = 1'b0;
        repeat (4) tick();

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)   bus.start = ~bus.start;
            bus.abort = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 199) == 0) force_fin = ~force_fin;
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
